// File: rtl/tdc_frame_sequencer.sv
// rtl/tdc_frame_sequencer.sv - sparse TDC hits to dense per-pixel shot stream for the histogram builder
// Optional drop counter enabled by defining TDC_SEQ_DROPCNT_EN.
module tdc_frame_sequencer #(
  parameter int NP         = 14,
  parameter int DATA_NUM   = 4,
  parameter int PIXEL_NUM  = 200,
  parameter int ACQ_NUM    = 33333,
  parameter int FIFO_DEPTH = 16,
  localparam int PW        = $clog2(PIXEL_NUM)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pixel,
  input  logic [NP-1:0] in_data,
  input  logic          in_nohit,
  input  logic          in_last,
  output logic          wrEn,
  output logic [NP-1:0] data,
  output logic          frame_done,
  output logic [19:0]   acq_idx,
  output logic [15:0]   drop_count
);

  localparam int KW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = NP + PW + 2;
  localparam logic [NP-1:0] PAD       = '1;
  localparam logic [NP-1:0] PAD_ALIAS = {{(NP-1){1'b1}}, 1'b0};
  localparam logic [PW:0]   PIX_NUM_W = (PW+1)'(PIXEL_NUM);
  localparam logic [PW-1:0] PIX_LAST  = PW'(PIXEL_NUM - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(DATA_NUM - 1);
  localparam logic [19:0]   ACQ_LAST  = 20'(ACQ_NUM - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ready_en, push, pop, empty;
  logic [NP-1:0] wr_data;
  logic          head_last, head_nohit;
  logic [PW-1:0] head_pixel;
  logic [NP-1:0] head_data;

  state_t        state, state_n;
  logic [PW-1:0] pix, pix_n;
  logic [KW-1:0] k, k_n;
  logic          seen, seen_n;
  logic          adv, emit_n, drop;
  logic [NP-1:0] emit_data;

  // ready_en keeps in_ready low while res is held and for the reset cycle itself
  assign in_ready = ready_en && (count != FIFO_FULL);
  assign push     = in_valid && in_ready;
  assign empty    = (count == '0);
  assign wr_data  = (in_data == PAD) ? PAD_ALIAS : in_data;
  assign {head_last, head_nohit, head_pixel, head_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_nohit, in_pixel, wr_data};
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    pix_n     = pix;
    k_n       = k;
    seen_n    = seen;
    pop       = 1'b0;
    drop      = 1'b0;
    adv       = 1'b0;
    emit_n    = 1'b0;
    emit_data = PAD;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_n = RUN;
          pix_n   = '0;
          k_n     = '0;
          seen_n  = 1'b0;
        end
      end
      RUN: begin
        if (seen) begin
          adv = 1'b1;
        end else if (!empty) begin
          if (head_nohit) begin
            pop    = 1'b1;
            seen_n = 1'b1;
            adv    = 1'b1;
          end else if (head_pixel < pix || {1'b0, head_pixel} >= PIX_NUM_W) begin
            // a dropped word still closes the shot if it carries last
            pop  = 1'b1;
            drop = 1'b1;
            if (head_last) seen_n = 1'b1;
          end else if (head_pixel == pix) begin
            pop       = 1'b1;
            adv       = 1'b1;
            emit_data = head_data;
            if (head_last) seen_n = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
        if (adv) begin
          emit_n = 1'b1;
          if (k == K_LAST) begin
            k_n = '0;
            if (pix == PIX_LAST) state_n = seen_n ? DONE : DRAIN;
            else                 pix_n   = pix + PW'(1);
          end else begin
            k_n = k + KW'(1);
          end
        end
      end
      DRAIN: begin
        if (!empty) begin
          pop  = 1'b1;
          drop = !head_nohit;
          if (head_last) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      pix        <= '0;
      k          <= '0;
      seen       <= 1'b0;
      wrEn       <= 1'b0;
      data       <= '0;
      frame_done <= 1'b0;
      acq_idx    <= '0;
    end else begin
      state      <= state_n;
      pix        <= pix_n;
      k          <= k_n;
      seen       <= seen_n;
      wrEn       <= emit_n;
      if (emit_n) data <= emit_data;
      frame_done <= (state == DONE) && (acq_idx == ACQ_LAST);
      if (state == DONE) acq_idx <= (acq_idx == ACQ_LAST) ? '0 : acq_idx + 20'd1;
    end
  end

`ifdef TDC_SEQ_DROPCNT_EN
  always_ff @(posedge clk) begin
    if (res)                               drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign drop_count  = '0;
`endif

endmodule
